// File: rtl/sprite_compositor.sv
// Sprite compositor: hit-tests one sprite per pixel, fetches its colour index
// from the external sprite ROM, resolves it through the shadowed palette and
// composites over the background. Fixed 3-cycle latency, one pixel per cycle.
module sprite_compositor #(
    parameter int SPR_W  = 64,
    parameter int SPR_H  = 64,
    parameter int X_W    = 10,
    parameter int Y_W    = 10,
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic [X_W-1:0]    i_sprite_x,
    input  logic [Y_W-1:0]    i_sprite_y,
    input  logic              i_flip,
    input  logic              i_visible,
    input  logic [383:0]      i_palette,
    input  logic              i_pix_valid,
    input  logic [X_W-1:0]    i_pix_x,
    input  logic [Y_W-1:0]    i_pix_y,
    input  logic [23:0]       i_bg_rgb,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [3:0]        i_rom_idx,
    output logic              o_pix_valid,
    output logic [23:0]       o_rgb,
    output logic              o_hit,
    output logic [ADDR_W:0]   o_hit_count
);

    localparam int RX_W  = $clog2(SPR_W);
    localparam int RY_W  = ADDR_W - RX_W;
    localparam int CNT_W = ADDR_W + 1;

    // Shadow copies of the sprite configuration, only updated in blanking.
    logic              sh_visible;
    logic [X_W-1:0]    sh_x;
    logic [Y_W-1:0]    sh_y;
    logic              sh_flip;
    logic [383:0]      sh_palette;

    // Stage 0 (combinational on the incoming pixel).
    logic [X_W:0]      px_e, sx_e, sx_end;
    logic [Y_W:0]      py_e, sy_e, sy_end;
    logic              in_box0;
    logic [RX_W-1:0]   rx_lo, rx_f;
    logic [RY_W-1:0]   ry_lo;
    logic [ADDR_W-1:0] addr0;

    // Stage 1 / stage 2 pipeline registers.
    logic              s1_valid, s1_inbox;
    logic [23:0]       s1_bg;
    logic              s2_valid, s2_inbox;
    logic [23:0]       s2_bg;

    // Stage 2 resolution.
    logic [23:0]       pal [16];
    logic              opaque2;
    logic [23:0]       colour2;

    // Hit counter.
    logic [CNT_W-1:0]  running;
    logic [CNT_W-1:0]  running_inc;

    // Latch the sprite configuration at frame start.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sh_visible <= 1'b0;
            sh_x       <= '0;
            sh_y       <= '0;
            sh_flip    <= 1'b0;
            sh_palette <= '0;
        end else if (i_frame_start) begin
            sh_visible <= i_visible;
            sh_x       <= i_sprite_x;
            sh_y       <= i_sprite_y;
            sh_flip    <= i_flip;
            sh_palette <= i_palette;
        end
    end

    // Hit test and ROM address; bounds use one extra bit so the box never wraps.
    always_comb begin
        px_e    = {1'b0, i_pix_x};
        sx_e    = {1'b0, sh_x};
        sx_end  = sx_e + (X_W+1)'(SPR_W);
        py_e    = {1'b0, i_pix_y};
        sy_e    = {1'b0, sh_y};
        sy_end  = sy_e + (Y_W+1)'(SPR_H);
        in_box0 = sh_visible & i_pix_valid &
                  (px_e >= sx_e) & (px_e < sx_end) &
                  (py_e >= sy_e) & (py_e < sy_end);
        // Only the low bits of the offsets matter inside the box.
        rx_lo   = RX_W'(i_pix_x) - RX_W'(sh_x);
        ry_lo   = RY_W'(i_pix_y) - RY_W'(sh_y);
        // SPR_W-1-rx is the bitwise complement for a power-of-two width.
        rx_f    = sh_flip ? ~rx_lo : rx_lo;
        addr0   = {ry_lo, rx_f};
    end

    // Stage 1: present the ROM address and carry pixel context.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid   <= 1'b0;
            s1_inbox   <= 1'b0;
            s1_bg      <= '0;
            o_rom_addr <= '0;
        end else begin
            s1_valid   <= i_pix_valid;
            s1_inbox   <= in_box0;
            s1_bg      <= i_bg_rgb;
            o_rom_addr <= in_box0 ? addr0 : '0;
        end
    end

    // Stage 2 context, aligned with the ROM read data.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_valid <= 1'b0;
            s2_inbox <= 1'b0;
            s2_bg    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_inbox <= s1_inbox;
            s2_bg    <= s1_bg;
        end
    end

    // Unpack the shadow palette into 16 entries.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            pal[k] = sh_palette[24*k +: 24];
        end
    end

    // Resolve the colour index; index 0 is transparent.
    always_comb begin
        opaque2 = s2_valid & s2_inbox & (i_rom_idx != 4'd0);
        colour2 = opaque2 ? pal[i_rom_idx] : s2_bg;
    end

    // Output register; colour and hit are forced low between strobes.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_pix_valid <= 1'b0;
            o_rgb       <= '0;
            o_hit       <= 1'b0;
        end else begin
            o_pix_valid <= s2_valid;
            o_rgb       <= s2_valid ? colour2 : '0;
            o_hit       <= opaque2;
        end
    end

    assign running_inc = (o_hit && (running != {CNT_W{1'b1}})) ? running + 1'b1 : running;

    // Saturating per-frame hit count; the frame-start cycle's own hit is included.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            running     <= '0;
            o_hit_count <= '0;
        end else if (i_frame_start) begin
            o_hit_count <= running_inc;
            running     <= '0;
        end else begin
            running     <= running_inc;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: table of single-pixel vectors plus
// hand-written sequences for counting, shadowing, reset and streaming.
module tb_sprite_compositor;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_frame_start;
    logic [9:0]   i_sprite_x;
    logic [9:0]   i_sprite_y;
    logic         i_flip;
    logic         i_visible;
    logic [383:0] i_palette;
    logic         i_pix_valid;
    logic [9:0]   i_pix_x;
    logic [9:0]   i_pix_y;
    logic [23:0]  i_bg_rgb;
    logic [11:0]  o_rom_addr;
    logic [3:0]   i_rom_idx;
    logic         o_pix_valid;
    logic [23:0]  o_rgb;
    logic         o_hit;
    logic [12:0]  o_hit_count;

    int checks = 0;
    int errors = 0;

    sprite_compositor dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_frame_start (i_frame_start),
        .i_sprite_x    (i_sprite_x),
        .i_sprite_y    (i_sprite_y),
        .i_flip        (i_flip),
        .i_visible     (i_visible),
        .i_palette     (i_palette),
        .i_pix_valid   (i_pix_valid),
        .i_pix_x       (i_pix_x),
        .i_pix_y       (i_pix_y),
        .i_bg_rgb      (i_bg_rgb),
        .o_rom_addr    (o_rom_addr),
        .i_rom_idx     (i_rom_idx),
        .o_pix_valid   (o_pix_valid),
        .o_rgb         (o_rgb),
        .o_hit         (o_hit),
        .o_hit_count   (o_hit_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [9:0]  sx;
        logic [9:0]  sy;
        logic        flip;
        logic        vis;
        logic [9:0]  px;
        logic [9:0]  py;
        logic [23:0] bg;
        logic [3:0]  idx;
        logic [11:0] ea;
        logic [23:0] ergb;
        logic        eh;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic frame_pulse(input logic [9:0] sx, input logic [9:0] sy,
                               input logic flip, input logic vis);
        i_sprite_x    = sx;
        i_sprite_y    = sy;
        i_flip        = flip;
        i_visible     = vis;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
    endtask

    // One isolated pixel: address at N+1, ROM data at N+2, result at N+3.
    task automatic run_vec(input string tag, input logic [9:0] px, input logic [9:0] py,
                           input logic [23:0] bg, input logic [3:0] idx,
                           input logic [11:0] ea, input logic [23:0] ergb, input logic eh);
        i_pix_valid = 1'b1;
        i_pix_x     = px;
        i_pix_y     = py;
        i_bg_rgb    = bg;
        tick();
        i_pix_valid = 1'b0;
        i_bg_rgb    = 24'h0;
        i_rom_idx   = idx;
        chk({tag, ".rom_addr"}, 32'(o_rom_addr), 32'(ea));
        tick();
        i_rom_idx   = idx;
        tick();
        chk({tag, ".valid"}, 32'(o_pix_valid), 32'd1);
        chk({tag, ".rgb"},   32'(o_rgb),       32'(ergb));
        chk({tag, ".hit"},   32'(o_hit),       32'(eh));
        tick();
        chk({tag, ".idle_valid"}, 32'(o_pix_valid), 32'd0);
        chk({tag, ".idle_rgb"},   32'(o_rgb),       32'd0);
        i_rom_idx = 4'd0;
    endtask

    initial begin
        int strobes;

        for (int k = 0; k < 16; k++) begin
            i_palette[24*k +: 24] = (k == 5) ? 24'h7efe00 : {3{8'(k)}};
        end
        i_rst_n = 1'b0;
        i_frame_start = 1'b0;
        i_sprite_x = 10'd0;
        i_sprite_y = 10'd0;
        i_flip = 1'b0;
        i_visible = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_x = 10'd0;
        i_pix_y = 10'd0;
        i_bg_rgb = 24'h0;
        i_rom_idx = 4'd0;

        //          sx       sy      flip  vis   px        py        bg          idx   addr      rgb         hit
        vecs[0]  = '{10'd100, 10'd50, 1'b0, 1'b1, 10'd100,  10'd50,  24'h111111, 4'd5, 12'd0,    24'h7efe00, 1'b1};
        vecs[1]  = '{10'd100, 10'd50, 1'b1, 1'b1, 10'd100,  10'd51,  24'h222222, 4'd3, 12'd127,  24'h030303, 1'b1};
        vecs[2]  = '{10'd100, 10'd50, 1'b0, 1'b1, 10'd101,  10'd50,  24'h123456, 4'd0, 12'd1,    24'h123456, 1'b0};
        vecs[3]  = '{10'd100, 10'd50, 1'b0, 1'b1, 10'd99,   10'd50,  24'habcdef, 4'd5, 12'd0,    24'habcdef, 1'b0};
        vecs[4]  = '{10'd1000,10'd50, 1'b0, 1'b1, 10'd1023, 10'd50,  24'h333333, 4'd7, 12'd23,   24'h070707, 1'b1};
        vecs[5]  = '{10'd1000,10'd50, 1'b0, 1'b1, 10'd5,    10'd50,  24'h0000ff, 4'd7, 12'd0,    24'h0000ff, 1'b0};
        vecs[6]  = '{10'd100, 10'd50, 1'b0, 1'b1, 10'd163,  10'd113, 24'h444444, 4'd2, 12'd4095, 24'h020202, 1'b1};
        vecs[7]  = '{10'd100, 10'd50, 1'b0, 1'b1, 10'd164,  10'd50,  24'h00ff00, 4'd2, 12'd0,    24'h00ff00, 1'b0};
        vecs[8]  = '{10'd100, 10'd50, 1'b0, 1'b1, 10'd100,  10'd114, 24'hff0000, 4'd2, 12'd0,    24'hff0000, 1'b0};
        vecs[9]  = '{10'd100, 10'd50, 1'b0, 1'b0, 10'd110,  10'd60,  24'h445566, 4'd4, 12'd0,    24'h445566, 1'b0};
        vecs[10] = '{10'd100, 10'd50, 1'b1, 1'b1, 10'd163,  10'd113, 24'h555555, 4'd1, 12'd4032, 24'h010101, 1'b1};
        vecs[11] = '{10'd100, 10'd50, 1'b0, 1'b1, 10'd120,  10'd70,  24'h666666, 4'd15,12'd1300, 24'h0f0f0f, 1'b1};

        // Reset state.
        tick();
        tick();
        chk("rst.valid", 32'(o_pix_valid), 32'd0);
        chk("rst.rgb",   32'(o_rgb),       32'd0);
        chk("rst.hit",   32'(o_hit),       32'd0);
        chk("rst.count", 32'(o_hit_count), 32'd0);
        chk("rst.addr",  32'(o_rom_addr),  32'd0);
        i_rst_n = 1'b1;
        tick();

        // Single-pixel vectors.
        for (int v = 0; v < 12; v++) begin
            frame_pulse(vecs[v].sx, vecs[v].sy, vecs[v].flip, vecs[v].vis);
            tick();
            run_vec($sformatf("vec%0d", v), vecs[v].px, vecs[v].py, vecs[v].bg,
                    vecs[v].idx, vecs[v].ea, vecs[v].ergb, vecs[v].eh);
        end

        // Three opaque pixels counted at the next frame start.
        frame_pulse(10'd100, 10'd50, 1'b0, 1'b1);
        run_vec("cnt_a", 10'd100, 10'd50, 24'h0, 4'd5, 12'd0, 24'h7efe00, 1'b1);
        run_vec("cnt_b", 10'd101, 10'd50, 24'h0, 4'd5, 12'd1, 24'h7efe00, 1'b1);
        run_vec("cnt_c", 10'd102, 10'd50, 24'h0, 4'd5, 12'd2, 24'h7efe00, 1'b1);
        frame_pulse(10'd100, 10'd50, 1'b0, 1'b1);
        chk("count3", 32'(o_hit_count), 32'd3);

        // Opaque output in the same cycle as frame start is included.
        i_pix_valid = 1'b1; i_pix_x = 10'd100; i_pix_y = 10'd50;
        tick();
        i_pix_x = 10'd101; i_rom_idx = 4'd5;
        tick();
        i_pix_valid = 1'b0;
        tick();
        chk("coinc.hit_a", 32'(o_hit), 32'd1);
        tick();
        chk("coinc.hit_b", 32'(o_hit), 32'd1);
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        i_rom_idx = 4'd0;
        chk("coinc.count", 32'(o_hit_count), 32'd2);
        tick();
        tick();
        frame_pulse(10'd100, 10'd50, 1'b0, 1'b1);
        chk("coinc.restart", 32'(o_hit_count), 32'd0);

        // Every pixel of the sprite opaque: 4096 hits, no wrap.
        i_rom_idx = 4'd5;
        for (int y = 0; y < 64; y++) begin
            for (int x = 0; x < 64; x++) begin
                i_pix_valid = 1'b1;
                i_pix_x = 10'(100 + x);
                i_pix_y = 10'(50 + y);
                tick();
            end
        end
        i_pix_valid = 1'b0;
        for (int t = 0; t < 4; t++) tick();
        i_rom_idx = 4'd0;
        frame_pulse(10'd100, 10'd50, 1'b0, 1'b1);
        chk("count4096", 32'(o_hit_count), 32'd4096);

        // Mid-frame position change is ignored until the next frame start.
        i_sprite_x = 10'd500;
        tick();
        run_vec("shadow_old", 10'd101, 10'd50, 24'h777777, 4'd5, 12'd1, 24'h7efe00, 1'b1);
        frame_pulse(10'd500, 10'd50, 1'b0, 1'b1);
        run_vec("shadow_new", 10'd101, 10'd50, 24'h777777, 4'd5, 12'd0, 24'h777777, 1'b0);

        // 640-pixel continuous stream, all outside the box: bg out 3 cycles later.
        frame_pulse(10'd100, 10'd50, 1'b0, 1'b1);
        tick();
        strobes = 0;
        for (int k = 0; k < 644; k++) begin
            if (k < 640) begin
                i_pix_valid = 1'b1;
                i_pix_x = 10'(k);
                i_pix_y = 10'd200;
                i_bg_rgb = 24'h100000 + 24'(k);
            end else begin
                i_pix_valid = 1'b0;
            end
            if (o_pix_valid) strobes++;
            if (k >= 3 && k < 643) begin
                chk($sformatf("stream%0d.valid", k - 3), 32'(o_pix_valid), 32'd1);
                chk($sformatf("stream%0d.rgb", k - 3), 32'(o_rgb), 32'(24'h100000 + 24'(k - 3)));
            end else begin
                chk($sformatf("stream_idle%0d", k), 32'(o_pix_valid), 32'd0);
            end
            tick();
        end
        chk("stream.strobes", 32'(strobes), 32'd640);

        // Reset with three pixels in flight.
        i_rom_idx = 4'd5;
        i_pix_valid = 1'b1; i_pix_x = 10'd100; i_pix_y = 10'd50;
        tick();
        i_pix_x = 10'd101;
        tick();
        i_pix_x = 10'd102;
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        i_pix_valid = 1'b0;
        for (int t = 0; t < 5; t++) begin
            chk($sformatf("rst_flight%0d.valid", t), 32'(o_pix_valid), 32'd0);
            tick();
        end
        chk("rst_flight.count", 32'(o_hit_count), 32'd0);
        i_rom_idx = 4'd0;
        // Shadows were cleared: sprite invisible until the next frame start.
        run_vec("rst_shadow", 10'd100, 10'd50, 24'h888888, 4'd5, 12'd0, 24'h888888, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Pixel-pipeline stage directly downstream of the per-player palette modules.
- Per VGA pixel: hit-tests one sprite, addresses the sprite index ROM, and resolves the returned 4-bit colour index through the 16-entry palette.
- Composites the result over the incoming background colour (index 0 = transparent) and feeds the next layer or the VGA output.
- Also counts the opaque pixels drawn per frame, for collision and debug use.

Parameters:
- SPR_W, 64, sprite width in pixels (power of two).
- SPR_H, 64, sprite height in pixels.
- X_W, 10, pixel x-coordinate width.
- Y_W, 10, pixel y-coordinate width.
- ADDR_W, 12, sprite ROM address width, equal to log2(SPR_W*SPR_H).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_frame_start  in  1  one-cycle pulse at frame start (in blanking); latches the shadow registers.
- i_sprite_x  in  X_W  sprite left edge.
- i_sprite_y  in  Y_W  sprite top edge.
- i_flip  in  1  horizontal mirror.
- i_visible  in  1  sprite enable.
- i_palette  in  384  16 colours; entry k occupies bits [24k+23:24k].
- i_pix_valid  in  1  pixel strobe.
- i_pix_x  in  X_W  pixel x coordinate.
- i_pix_y  in  Y_W  pixel y coordinate.
- i_bg_rgb  in  24  background colour for this pixel.
- o_rom_addr  out  ADDR_W  sprite ROM address.
- i_rom_idx  in  4  ROM data; synchronous read, valid one cycle after o_rom_addr.
- o_pix_valid  out  1  output strobe.
- o_rgb  out  24  composited colour.
- o_hit  out  1  opaque sprite pixel drawn.
- o_hit_count  out  ADDR_W+1  opaque pixels drawn in the last completed frame.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - All pipeline valids cleared.
  - o_rom_addr=0, o_pix_valid=0, o_rgb=0, o_hit=0, o_hit_count=0, running counter=0.
  - Shadow registers cleared: visible=0, x=0, y=0, flip=0, palette all 0.
  - Reset mid-frame discards every in-flight pixel; no output strobe follows it.
- Shadow update: on i_frame_start, latch i_sprite_x, i_sprite_y, i_flip, i_visible and i_palette. Mid-frame changes to these inputs have no effect until the next i_frame_start.
- Stage 0, input cycle N:
  - in_box = visible & valid & (px >= sx) & (px < sx+SPR_W) & (py >= sy) & (py < sy+SPR_H).
  - Sums are computed at X_W+1 / Y_W+1 bits, so there is no wrap-around.
  - rx = px-sx, ry = py-sy; with flip, rx' = SPR_W-1-rx.
  - addr = ry*SPR_W + rx'.
- Stage 1, cycle N+1:
  - o_rom_addr = addr when in_box, else 0.
  - valid, in_box and bg are carried forward.
- Stage 2, cycle N+2:
  - i_rom_idx holds the index for that address.
  - opaque = in_box & (idx != 0).
  - Colour = palette[idx] if opaque, else bg. The palette is read from the shadow register at this stage.
- Output, cycle N+3:
  - o_pix_valid=1, o_rgb = colour, o_hit = opaque. Latency is exactly 3 cycles.
  - When o_pix_valid=0: o_rgb=0 and o_hit=0.
- Throughput: one pixel per cycle. Gaps in i_pix_valid pass through as bubbles.
- Hit counter:
  - Increments on each cycle with o_hit=1, saturating at 2^(ADDR_W+1)-1.
  - On i_frame_start: o_hit_count <= running + (o_hit this cycle), and running <= 0.
- i_frame_start while pixels are in flight:
  - Pixels past stage 0 keep their old geometry.
  - Pixels at stage 2 or later see the new palette. This is permitted because frame_start falls in blanking.
- i_visible=0: every pixel passes bg through, o_hit=0, o_rom_addr=0.

Test Plan:
- Shadows (100,50), flip=0, palette[5]=7efe00. Pixel (100,50) at N, ROM returns 5 -> o_rom_addr=0 at N+1; o_pix_valid=1, o_rgb=7efe00, o_hit=1 at N+3.
- Same setup with flip=1, pixel (100,51) -> o_rom_addr=64+63=127 at N+1.
- ROM returns idx 0 with bg=123456 -> o_rgb=123456, o_hit=0.
- Pixel (99,50) -> o_rom_addr=0, o_rgb=bg, o_hit=0.
- sx=1000: pixel x=1023 is in box (rx=23); pixel x=5 is out (no wrap).
- Boundary: pixel (163,113) is in box; pixels (164,50) and (100,114) are out.
- Counter: 3 opaque pixels, then i_frame_start -> o_hit_count=3.
  - Opaque output coincident with i_frame_start -> count includes it; running restarts at 0.
  - 4096 forced hits -> count=4096, no wrap.
- Change i_sprite_x mid-frame -> hit test unchanged until i_frame_start.
- Reset asserted with 3 pixels in flight -> o_pix_valid stays 0 and o_hit_count=0.
- Continuous valid for 640 pixels -> 640 output strobes, contiguous, each delayed by 3 cycles.
